nibble_serial_adder: RTL and testbench

//  Sequenced multi-word adder built around the 4-bit ripple-carry stage.
//  - Accepts WIDTH-bit operands through a valid/ready handshake.
//  - Adds one 4-bit slice per clock, from the least significant slice upward.
//  - Carries between slices through a registered carry flop.
//  - Returns the full sum plus carry-out through a valid/ready handshake.
//  - Sits between an operand producer and a result consumer. Trades latency for a single 4-bit adder datapath.

---
 rtl/nibble_serial_adder_if.sv | 26 ++
 rtl/nibble_serial_adder.sv | 101 ++++++++++
 tb/tb_nibble_serial_adder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The slave modport is the adder side; master is the producer/consumer side.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that processes one 4-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a flop. Results are returned via valid/ready.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [4:0]       slice_res;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        partial_d = partial_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        idx_d     = idx_q;
        slice_res = {1'b0, a_q[4*idx_q +: 4]} + {1'b0, b_q[4*idx_q +: 4]}
                  + {4'b0000, carry_q};

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    carry_d   = bus.cin;
                    idx_d     = '0;
                    partial_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                partial_d[4*idx_q +: 4] = slice_res[3:0];
                carry_d = slice_res[4];
                // idx stops at the last slice instead of wrapping; acceptance clears it
                if (idx_q == LAST_IDX) begin
                    sum_d   = partial_d;
                    cout_d  = slice_res[4];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;
    logic        clk;
    logic        rst_n;
    logic [15:0] drv_a, drv_b;
    logic        drv_cin, drv_iv, drv_or;
    logic        sel4;
    int          total, bad;

    nibble_serial_adder_if #(.WIDTH(16)) if16 ();
    nibble_serial_adder_if #(.WIDTH(4))  if4 ();

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    nibble_serial_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    assign if16.a         = drv_a;
    assign if16.b         = drv_b;
    assign if16.cin       = drv_cin;
    assign if16.in_valid  = drv_iv & ~sel4;
    assign if16.out_ready = drv_or & ~sel4;
    assign if4.a          = drv_a[3:0];
    assign if4.b          = drv_b[3:0];
    assign if4.cin        = drv_cin;
    assign if4.in_valid   = drv_iv & sel4;
    assign if4.out_ready  = drv_or & sel4;

    logic [15:0] o_sum;
    logic        o_cout, o_valid, o_ready, o_busy;
    assign o_sum   = sel4 ? {12'h000, if4.sum} : if16.sum;
    assign o_cout  = sel4 ? if4.cout      : if16.cout;
    assign o_valid = sel4 ? if4.out_valid : if16.out_valid;
    assign o_ready = sel4 ? if4.in_ready  : if16.in_ready;
    assign o_busy  = sel4 ? if4.busy      : if16.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the result handshake.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] es, input logic ec, input int stall,
                      input string nm);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, o_ready, 1'b1);
        drv_a = a; drv_b = b; drv_cin = ci; drv_iv = 1'b1; drv_or = 1'b0;
        @(negedge clk);
        drv_iv = 1'b0;
        wait_valid(n);
        chk({nm, "_latency"}, n, sel4 ? 1 : 4);
        repeat (stall) @(negedge clk);
        chk({nm, "_result"}, {o_cout, o_sum}, {ec, es});
        chk({nm, "_busy_ir"}, {o_busy, o_ready}, 2'b10);
        drv_or = 1'b1;
        @(negedge clk);
        drv_or = 1'b0;
        chk({nm, "_idle"}, {o_valid, o_busy, o_ready}, 3'b001);
    endtask

    initial begin
        int n;
        logic [16:0] full;
        logic [4:0]  f4;
        logic [15:0] ra, rb;
        logic        rc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic"};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ones_plus_b"};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ones_plus_cin"};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, "cin_only"};
        vecs[4] = '{16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1, "mixed_carry"};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, "no_cout"};
        vecs[6] = '{16'hA5A5, 16'h0F0F, 1'b0, 16'hB4B4, 1'b0, "alt"};

        total = 0; bad = 0; sel4 = 1'b0;
        drv_a = '0; drv_b = '0; drv_cin = 1'b0; drv_iv = 1'b0; drv_or = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {o_valid, o_busy, o_ready, o_cout, o_sum}, {4'b0010, 16'h0000});
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, i % 3, vecs[i].name);

        // held result under backpressure; new operands while busy must be ignored
        drv_a = 16'h8000; drv_b = 16'h8000; drv_cin = 1'b1; drv_iv = 1'b1; drv_or = 1'b0;
        @(negedge clk);
        chk("hold_busy", {o_busy, o_ready}, 2'b10);
        drv_a = 16'h1111; drv_b = 16'h2222; drv_cin = 1'b0;
        wait_valid(n);
        chk("hold_latency", n, 4);
        repeat (6) @(negedge clk);
        chk("hold_result", {o_cout, o_sum}, 17'h10001);
        chk("hold_flags", {o_valid, o_ready}, 2'b10);
        drv_or = 1'b1;
        @(negedge clk);
        drv_or = 1'b0;
        chk("hold_idle", {o_valid, o_ready}, 2'b01);
        @(negedge clk);
        chk("hold_reaccept", {o_busy, o_ready}, 2'b10);
        drv_iv = 1'b0;
        wait_valid(n);
        chk("hold_second", {o_cout, o_sum}, 17'h03333);
        drv_or = 1'b1;
        @(negedge clk);
        drv_or = 1'b0;

        // asynchronous abort two edges into a run
        drv_a = 16'hAAAA; drv_b = 16'h5555; drv_cin = 1'b0; drv_iv = 1'b1;
        @(negedge clk);
        drv_iv = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", {o_valid, o_busy, o_ready, o_cout, o_sum}, {4'b0010, 16'h0000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            op(ra, rb, rc, full[15:0], full[16], $urandom_range(0, 3), "rand16");
        end

        sel4 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            f4 = {1'b0, ra[3:0]} + {1'b0, rb[3:0]} + {4'h0, rc};
            op(ra, rb, rc, {12'h000, f4[3:0]}, f4[4], $urandom_range(0, 3), "rand4");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
